// File: rtl/decode_stage_pipe_pkg.sv
// Shared RV32I decode constants, immediate formats and the registered output bundle.
// Bundle widths are fixed to RV32I (32-bit data, 5-bit register index).
package decode_stage_pipe_pkg;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LD    = 7'b0000011;
  localparam logic [6:0] OPCODE_ST    = 7'b0100011;
  localparam logic [6:0] OPCODE_BR    = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;

  localparam int unsigned BUNDLE_XLEN     = 32;
  localparam int unsigned BUNDLE_REG_BITS = 5;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic [BUNDLE_XLEN-1:0]     pc;
    logic [6:0]                 opcode;
    logic [2:0]                 funct3;
    logic [6:0]                 funct7;
    logic [BUNDLE_REG_BITS-1:0] rd;
    logic [BUNDLE_XLEN-1:0]     rs1_data;
    logic [BUNDLE_XLEN-1:0]     rs2_data;
    logic [BUNDLE_XLEN-1:0]     imm_se;
  } decode_bundle_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OPCODE_ST:               return IMM_S;
      OPCODE_BR:               return IMM_B;
      OPCODE_LUI, OPCODE_AUIPC: return IMM_U;
      OPCODE_JAL:              return IMM_J;
      default:                 return IMM_I;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] i);
    case (imm_fmt(i[6:0]))
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OPCODE_OP) || (op == OPCODE_OPIMM) || (op == OPCODE_LD) ||
           (op == OPCODE_ST) || (op == OPCODE_BR) || (op == OPCODE_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OPCODE_OP) || (op == OPCODE_ST) || (op == OPCODE_BR);
  endfunction

endpackage

// File: rtl/decode_stage_pipe_regfile.sv
// Architectural register file: two asynchronous reads, one synchronous write,
// synchronous clear on reset. x0 always reads zero and ignores writes.
module regfile_2r1w
  import decode_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned REG_BITS = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [REG_BITS-1:0] rd_addr_a,
  output logic [XLEN-1:0]     rd_data_a,
  input  logic [REG_BITS-1:0] rd_addr_b,
  output logic [XLEN-1:0]     rd_data_b,
  input  logic                wr_en,
  input  logic [REG_BITS-1:0] wr_addr,
  input  logic [XLEN-1:0]     wr_data
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage with valid/ready handshake and a registered bundle (1-cycle latency).
// Define DECODE_WB_BYPASS_EN to forward a same-cycle writeback into the captured operands.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned REG_BITS = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [XLEN-1:0]     instr_i,
  input  logic                flush_i,
  input  logic                ex_ld_valid,
  input  logic [REG_BITS-1:0] ex_ld_rd,
  input  logic                wr_en,
  input  logic [REG_BITS-1:0] wr_rd,
  input  logic [XLEN-1:0]     wr_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     pc_o,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [REG_BITS-1:0] rd,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  output logic [XLEN-1:0]     imm_se,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [6:0]          op;
  logic [REG_BITS-1:0] rs1_idx, rs2_idx;
  logic [XLEN-1:0]     rf_rs1, rf_rs2, rs1_val, rs2_val;
  logic                hazard, adv, accept;

  logic                out_valid_q;
  decode_bundle_t      bundle_q, bundle_d;
  logic [CNT_W-1:0]    stall_q;

  assign op      = instr_i[6:0];
  assign rs1_idx = instr_i[15 +: REG_BITS];
  assign rs2_idx = instr_i[20 +: REG_BITS];

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_addr_a (rs1_idx),
    .rd_data_a (rf_rs1),
    .rd_addr_b (rs2_idx),
    .rd_data_b (rf_rs2),
    .wr_en     (wr_en),
    .wr_addr   (wr_rd),
    .wr_data   (wr_data)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_val = (wr_en && (wr_rd != '0) && (wr_rd == rs1_idx)) ? wr_data : rf_rs1;
  assign rs2_val = (wr_en && (wr_rd != '0) && (wr_rd == rs2_idx)) ? wr_data : rf_rs2;
`else
  // Writeback lands at the edge, so a same-cycle write is not seen here.
  assign rs1_val = rf_rs1;
  assign rs2_val = rf_rs2;
`endif

  // Load-use: the EX load's result is not available in time for this decode.
  assign hazard = in_valid && ex_ld_valid && (ex_ld_rd != '0) &&
                  ((uses_rs1(op) && (ex_ld_rd == rs1_idx)) ||
                   (uses_rs2(op) && (ex_ld_rd == rs2_idx)));

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = reset_n && adv && !hazard && !flush_i;
  assign accept   = in_valid && in_ready;

  always_comb begin
    bundle_d = bundle_q;
    if (accept) begin
      bundle_d.pc       = pc_i;
      bundle_d.opcode   = op;
      bundle_d.funct3   = instr_i[14:12];
      bundle_d.funct7   = instr_i[31:25];
      bundle_d.rd       = instr_i[11:7];
      bundle_d.rs1_data = rs1_val;
      bundle_d.rs2_data = rs2_val;
      bundle_d.imm_se   = gen_imm(instr_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      stall_q     <= '0;
    end else begin
      if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (adv) begin
        out_valid_q <= accept;
      end
      bundle_q <= bundle_d;
      if (hazard && adv && !flush_i && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign pc_o      = bundle_q.pc;
  assign opcode    = bundle_q.opcode;
  assign funct3    = bundle_q.funct3;
  assign funct7    = bundle_q.funct7;
  assign rd        = bundle_q.rd;
  assign rs1_data  = bundle_q.rs1_data;
  assign rs2_data  = bundle_q.rs2_data;
  assign imm_se    = bundle_q.imm_se;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios, randomized traffic and counter saturation,
// all checked against a cycle-level reference model built from the decode rules.
module tb_decode_stage_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned RB    = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid, in_ready, flush_i, ex_ld_valid, wr_en, out_valid, out_ready;
  logic [XLEN-1:0] pc_i, instr_i, wr_data, pc_o, rs1_data, rs2_data, imm_se;
  logic [RB-1:0]   ex_ld_rd, wr_rd, rd;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_stage_pipe #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pc_i        (pc_i),
    .instr_i     (instr_i),
    .flush_i     (flush_i),
    .ex_ld_valid (ex_ld_valid),
    .ex_ld_rd    (ex_ld_rd),
    .wr_en       (wr_en),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pc_o        (pc_o),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rd          (rd),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm_se      (imm_se),
    .stall_cnt   (stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference state.
  logic        m_ov;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_ins;
  int unsigned m_stall;
  logic [31:0] m_rf [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic signed [31:0] s;
    logic [31:0] sgn, hi;
    s   = ins;
    sgn = s >>> 31;
    case (ins[6:0])
      7'h23: begin
        hi = s >>> 25;
        return (hi << 5) | ((ins >> 7) & 32'h1f);
      end
      7'h63: return (sgn << 12) | (((ins >> 7) & 32'h1) << 11) |
                    (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
      7'h37, 7'h17: return ins & 32'hFFFFF000;
      7'h6F: return (sgn << 20) | (((ins >> 12) & 32'hff) << 12) |
                    (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1);
      default: begin
        hi = s >>> 20;
        return hi;
      end
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    if (idx == 0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wr_en && (int'(wr_rd) == idx)) return wr_data;
`endif
    return m_rf[idx];
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_ins = '0; m_stall = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  // One clock: check in_ready mid-cycle, advance the model, then check the registered outputs.
  task automatic step();
    bit adv, hz, rdy;
    int r1, r2;
    #1;
    r1  = int'(instr_i[19:15]);
    r2  = int'(instr_i[24:20]);
    adv = !m_ov || out_ready;
    hz  = in_valid && ex_ld_valid && (ex_ld_rd != 0) &&
          ((reads_rs1(instr_i[6:0]) && int'(ex_ld_rd) == r1) ||
           (reads_rs2(instr_i[6:0]) && int'(ex_ld_rd) == r2));
    rdy = reset_n && adv && !hz && !flush_i;
    check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    if (!reset_n) begin
      model_reset();
    end else begin
      if (in_valid && rdy) begin
        m_pc  = pc_i;
        m_ins = instr_i;
        m_rs1 = ref_read(r1);
        m_rs2 = ref_read(r2);
        m_imm = ref_imm(instr_i);
      end
      if (flush_i) m_ov = 1'b0;
      else if (adv) m_ov = in_valid && rdy;
      if (hz && adv && !flush_i && m_stall < 65535) m_stall++;
      if (wr_en && wr_rd != 0) m_rf[wr_rd] = wr_data;
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("stall_cnt", {16'b0, stall_cnt}, m_stall);
    check("pc_o", pc_o, m_pc);
    check("opcode", {25'b0, opcode}, {25'b0, m_ins[6:0]});
    check("funct3", {29'b0, funct3}, {29'b0, m_ins[14:12]});
    check("funct7", {25'b0, funct7}, {25'b0, m_ins[31:25]});
    check("rd", {27'b0, rd}, {27'b0, m_ins[11:7]});
    check("rs1_data", rs1_data, m_rs1);
    check("rs2_data", rs2_data, m_rs2);
    check("imm_se", imm_se, m_imm);
  endtask

  task automatic idle();
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
    ex_ld_valid = 1'b0; ex_ld_rd = '0; wr_en = 1'b0; wr_rd = '0; wr_data = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1; pc_i = pc; instr_i = ins;
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                             7'h73, 7'h7F};
    logic [31:0] ins;
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 10)];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  localparam logic [31:0] AddX3X2X1 = 32'h001101B3;
  localparam logic [31:0] AddX6X5X0 = 32'h00028333;

  initial begin
    idle();
    pc_i = '0; instr_i = '0;
    model_reset();

    // Reset for two cycles.
    reset_n = 1'b0;
    step();
    step();
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_stall", {16'b0, stall_cnt}, 32'h0);
    reset_n = 1'b1;
    issue(32'h0FC, AddX3X2X1);
    check("add_rs1_zero", rs1_data, 32'h0);
    check("add_rs2_zero", rs2_data, 32'h0);

    // Accept addi x1,x0,5.
    issue(32'h100, 32'h00500093);
    check("addi_valid", {31'b0, out_valid}, 32'h1);
    check("addi_imm", imm_se, 32'h5);
    check("addi_rd", {27'b0, rd}, 32'h1);
    check("addi_pc", pc_o, 32'h100);

    // Backpressure.
    issue(32'h200, 32'h00100113);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(32'h204, 32'h00200193);
      check("bp_hold_pc", pc_o, 32'h200);
    end
    out_ready = 1'b1;
    issue(32'h204, 32'h00200193);
    check("bp_release_pc", pc_o, 32'h204);

    // Load-use stall, then release.
    ex_ld_valid = 1'b1; ex_ld_rd = 5'd2;
    issue(32'h300, AddX3X2X1);
    check("lu_valid", {31'b0, out_valid}, 32'h0);
    check("lu_stall", {16'b0, stall_cnt}, 32'h1);
    ex_ld_valid = 1'b0;
    issue(32'h300, AddX3X2X1);
    check("lu_accept", {31'b0, out_valid}, 32'h1);

    // Immediate formats.
    issue(32'h400, 32'hFE000EE3);
    check("imm_b", imm_se, 32'hFFFFFFFC);
    issue(32'h404, 32'hFE000E63);
    check("imm_b2", imm_se, 32'hFFFFF7FC);
    issue(32'h408, 32'h800000EF);
    check("imm_j", imm_se, 32'hFFF00000);
    issue(32'h40C, 32'h123450B7);
    check("imm_u", imm_se, 32'h12345000);
    issue(32'h410, 32'hFE112E23);
    check("imm_s", imm_se, 32'hFFFFFFFC);

    // Writeback racing decode, then flush.
    in_valid = 1'b0; wr_en = 1'b1; wr_rd = 5'd5; wr_data = 32'h1234;
    step();
    wr_data = 32'hDEAD;
    issue(32'h500, AddX6X5X0);
    wr_en = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    check("wb_same_cycle", rs1_data, 32'hDEAD);
`else
    check("wb_same_cycle", rs1_data, 32'h1234);
`endif
    flush_i = 1'b1;
    issue(32'h504, 32'h00500093);
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    flush_i = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      reset_n     = ($urandom_range(0, 99) != 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 19) == 0);
      ex_ld_valid = ($urandom_range(0, 9) < 3);
      ex_ld_rd    = 5'($urandom_range(0, 7));
      wr_en       = ($urandom_range(0, 9) < 4);
      wr_rd       = 5'($urandom_range(0, 7));
      wr_data     = $urandom;
      pc_i        = $urandom & 32'hFFFFFFFC;
      instr_i     = rand_instr();
      step();
    end

    // Hold a load-use hazard long enough to saturate the counter.
    idle();
    ex_ld_valid = 1'b1; ex_ld_rd = 5'd2;
    in_valid = 1'b1; pc_i = 32'h600; instr_i = AddX3X2X1;
    for (int n = 0; n < 65540; n++) step();
    check("stall_saturated", {16'b0, stall_cnt}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
